// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the RV32I core.
// Optional macro FETCH_MISALIGN_TRAP_EN: trap on misaligned targets instead of masking PC[1:0].
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request outstanding at PC, waiting for ImemReady
// S_VALID | Instr held for decode, waiting for an unstalled Retire
// S_TRAP  | misaligned target seen, frozen until rst (macro builds only)
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCASRC,
   input  logic        PCBSRC,
   input  logic [31:0] Imm,
   input  logic [31:0] RS1,
   input  logic        Retire,
   input  logic        Stall,
   input  logic        ImemReady,
   input  logic [31:0] InstrIn,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] Instr,
   output logic        InstrValid,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        MisalignTrap,
`endif
   output logic [31:0] InstRet
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      S_TRAP  = 2'd2
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instret_q, instret_d;
   logic [31:0] next_pc;
   logic        retire_ok;

   // JALR clears bit 0 whenever rs1 is the base, including the unused 4+RS1 combination
   always_comb begin
      next_pc = (PCASRC ? 32'd4 : Imm) + (PCBSRC ? RS1 : pc_q);
      if (PCBSRC) begin
         next_pc[0] = 1'b0;
      end
   end

   assign retire_ok = Retire && !Stall;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      instret_d = instret_q;
      case (state_q)
         S_FETCH: begin
            if (ImemReady) begin
               instr_d = InstrIn;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (retire_ok) begin
               instret_d = instret_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (next_pc[1:0] != 2'b00) begin
                  state_d = S_TRAP;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_FETCH;
               end
`else
               pc_d    = next_pc & ~32'h3;
               state_d = S_FETCH;
`endif
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_TRAP: begin
            state_d = S_TRAP;
         end
`endif
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= 32'd0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
      end
   end

   assign ImemReq    = (state_q == S_FETCH);
   assign InstrValid = (state_q == S_VALID);
   assign ImemAddr   = pc_q;
   assign PC         = pc_q;
   assign PCPlus4    = pc_q + 32'd4;
   assign Instr      = instr_q;
   assign InstRet    = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign MisalignTrap = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with queued expected PCs and instructions.
// Builds with or without FETCH_MISALIGN_TRAP_EN.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCASRC, PCBSRC;
   logic [31:0] Imm, RS1;
   logic        Retire, Stall, ImemReady;
   logic [31:0] InstrIn;
   logic        ImemReq;
   logic [31:0] ImemAddr, PC, PCPlus4, Instr, InstRet;
   logic        InstrValid;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        MisalignTrap;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_instr_q[$];

   pc_fetch_unit #(.RESET_PC(32'h100)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCASRC     (PCASRC),
      .PCBSRC     (PCBSRC),
      .Imm        (Imm),
      .RS1        (RS1),
      .Retire     (Retire),
      .Stall      (Stall),
      .ImemReady  (ImemReady),
      .InstrIn    (InstrIn),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .PC         (PC),
      .PCPlus4    (PCPlus4),
      .Instr      (Instr),
      .InstrValid (InstrValid),
`ifdef FETCH_MISALIGN_TRAP_EN
      .MisalignTrap (MisalignTrap),
`endif
      .InstRet    (InstRet)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] word);
      ImemReady = 1'b1;
      InstrIn   = word;
      exp_instr_q.push_back(word);
      step();
      ImemReady = 1'b0;
      InstrIn   = 32'hDEAD_BEEF;
      chk("fetch_valid", {31'd0, InstrValid}, 32'd1);
      chk("fetch_req_low", {31'd0, ImemReq}, 32'd0);
      chk("fetch_instr", Instr, exp_instr_q.pop_front());
   endtask

   task automatic retire(input logic a, input logic b, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] exp_pc);
      PCASRC = a;
      PCBSRC = b;
      Imm    = imm;
      RS1    = rs1;
      Retire = 1'b1;
      exp_pc_q.push_back(exp_pc);
      step();
      Retire = 1'b0;
      Imm    = 32'h0;
      RS1    = 32'h0;
      chk("retire_pc", PC, exp_pc_q.pop_front());
      chk("retire_addr", ImemAddr, exp_pc);
      chk("retire_req", {31'd0, ImemReq}, 32'd1);
      chk("retire_valid_low", {31'd0, InstrValid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; PCASRC = 1'b1; PCBSRC = 1'b0; Imm = 32'h0; RS1 = 32'h0;
      Retire = 1'b0; Stall = 1'b0; ImemReady = 1'b0; InstrIn = 32'h0;
      step();
      step();
      rst = 1'b0;
      chk("rst_pc", PC, 32'h100);
      chk("rst_req", {31'd0, ImemReq}, 32'd1);
      chk("rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_instret", InstRet, 32'd0);
      chk("rst_instr", Instr, 32'd0);
      chk("rst_pcplus4", PCPlus4, 32'h104);

      fetch(32'h0000_0013);

      // sequential flow, one instruction per two cycles
      retire(1'b1, 1'b0, 32'h0, 32'h0, 32'h104);
      fetch(32'h0000_0093);
      retire(1'b1, 1'b0, 32'h0, 32'h0, 32'h108);
      fetch(32'h0000_0113);
      retire(1'b1, 1'b0, 32'h0, 32'h0, 32'h10C);
      chk("seq_instret", InstRet, 32'd3);

      // Retire while still fetching must be ignored
      Retire = 1'b1;
      step();
      Retire = 1'b0;
      chk("fetch_retire_pc", PC, 32'h10C);
      chk("fetch_retire_instret", InstRet, 32'd3);

      fetch(32'hFE00_0CE3);
      chk("branch_pcplus4", PCPlus4, 32'h110);
      retire(1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h104);
      fetch(32'h0200_006F);
      retire(1'b0, 1'b0, 32'h20, 32'h0, 32'h124);
      fetch(32'h0040_8067);
      retire(1'b0, 1'b1, 32'h4, 32'h201, 32'h204);
      chk("jalr_instret", InstRet, 32'd6);

      // memory not ready: request and address held, Instr unchanged
      for (int i = 0; i < 5; i++) begin
         step();
         chk("wait_req", {31'd0, ImemReq}, 32'd1);
         chk("wait_addr", ImemAddr, 32'h204);
         chk("wait_instr_hold", Instr, 32'h0040_8067);
      end
      fetch(32'h0000_0033);

      Stall = 1'b1; Retire = 1'b1; PCASRC = 1'b1; PCBSRC = 1'b0;
      step();
      Stall = 1'b0; Retire = 1'b0;
      chk("stall_pc", PC, 32'h204);
      chk("stall_valid", {31'd0, InstrValid}, 32'd1);
      chk("stall_instret", InstRet, 32'd6);

      retire(1'b1, 1'b0, 32'h0, 32'h0, 32'h208);

      // reset wins over a coincident ImemReady
      rst = 1'b1; ImemReady = 1'b1; InstrIn = 32'h1234_5678;
      step();
      rst = 1'b0; ImemReady = 1'b0;
      chk("rst_rdy_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_rdy_pc", PC, 32'h100);
      chk("rst_rdy_instr", Instr, 32'd0);
      chk("rst_rdy_instret", InstRet, 32'd0);

      fetch(32'h0060_0063);
`ifdef FETCH_MISALIGN_TRAP_EN
      PCASRC = 1'b0; PCBSRC = 1'b0; Imm = 32'h6; Retire = 1'b1;
      step();
      Retire = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("trap_flag", {31'd0, MisalignTrap}, 32'd1);
         chk("trap_req", {31'd0, ImemReq}, 32'd0);
         chk("trap_valid", {31'd0, InstrValid}, 32'd0);
         chk("trap_pc", PC, 32'h100);
         ImemReady = 1'b1; Retire = 1'b1;
         step();
         ImemReady = 1'b0; Retire = 1'b0;
      end
      chk("trap_instret", InstRet, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("trap_clear", {31'd0, MisalignTrap}, 32'd0);
      chk("trap_clear_req", {31'd0, ImemReq}, 32'd1);
`else
      retire(1'b0, 1'b0, 32'h6, 32'h0, 32'h104);
      chk("mask_instret", InstRet, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
